reg_file_dump_reader: RTL
=========================

REG_FILE_DUMP_READER -- requirements
Module: reg_file_dump_reader

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 0, first register index dumped.
REQ-002 The block SHALL have parameter LAST_REG, default 31, last register index dumped; FIRST_REG <= LAST_REG <= 31 is required.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-low.
REQ-005 Port start_i  input  1  request a dump, sampled in IDLE only.
REQ-006 Port abort_i  input  1  synchronous abort of a dump in progress.
REQ-007 Port read_register_o  output  5  address to a register-file read port, which returns combinational data.
REQ-008 Port read_data_i  input  32  combinational read data from that read port.
REQ-009 Port dump_valid_o  output  1  output beat valid.
REQ-010 Port dump_ready_i  input  1  downstream accepts the beat.
REQ-011 Port dump_data_o  output  32  captured register value.
REQ-012 Port dump_index_o  output  5  register index of dump_data_o.
REQ-013 Port busy_o  output  1  high in READ or SEND.
REQ-014 Port done_o  output  1  one-cycle pulse marking dump completion.

Function
REQ-015 The FSM SHALL have four states: IDLE, READ, SEND and DONE.
REQ-016 IDLE: when start_i=1 and abort_i=0, the FSM SHALL load index<=FIRST_REG and go to READ; otherwise it SHALL stay in IDLE.
REQ-017 read_register_o SHALL equal the index register in every state, and SHALL be 0 after reset.
REQ-018 READ SHALL take one cycle: dump_data_o<=read_data_i, dump_index_o<=index, dump_valid_o<=1, then go to SEND.
REQ-019 SEND: dump_valid_o, dump_data_o and dump_index_o SHALL stay stable until the handshake (dump_valid_o & dump_ready_i) completes.
REQ-020 On the handshake, if index==LAST_REG, the FSM SHALL clear dump_valid_o and go to DONE; otherwise it SHALL set index<=index+1, clear dump_valid_o and go to READ.
REQ-021 DONE SHALL assert done_o for exactly one cycle and then go to IDLE.
REQ-022 Throughput SHALL be one beat per 2 cycles with dump_ready_i held at 1; latency from start_i sampled to the first dump_valid_o SHALL be 2 cycles.
REQ-023 dump_ready_i SHALL have no effect outside SEND.
REQ-024 start_i asserted in READ, SEND or DONE SHALL be ignored, not queued.
REQ-025 abort_i=1 in READ or SEND SHALL force IDLE on the next edge, with dump_valid_o=0, busy_o=0 and no done_o pulse.
REQ-026 abort_i in IDLE or DONE SHALL be ignored; in IDLE, abort_i SHALL take priority over start_i.
REQ-027 abort_i and a handshake in the same SEND cycle: abort SHALL win, and the beat SHALL count as delivered.
REQ-028 The index SHALL never exceed LAST_REG and SHALL never wrap.
REQ-029 The block SHALL never drive a register-file write.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, index=0, and read_register_o, dump_valid_o, dump_data_o, dump_index_o, busy_o and done_o all 0.
REQ-031 Reset asserted mid-dump SHALL discard the dump with no done_o pulse.
REQ-032 After reset is released, the first start_i SHALL begin a fresh dump from FIRST_REG.

Verification
REQ-033 Default parameters, $t0(8)=0x0000_0008, $s0(16)=0xDEAD_BEEF, dump_ready_i=1, pulse start_i -> 32 beats, indices 0..31 in order; index 0 data 0x0; index 8 data 0x0000_0008; index 16 data 0xDEAD_BEEF; index 29 data 0x1001_0080 (MEMORY_DEPTH=32); done_o high for one cycle, 65 cycles after start_i is sampled.
REQ-034 Backpressure: dump_ready_i=0 for 5 cycles while index 4 is valid -> dump_data_o and dump_index_o=4 stay stable, no beat skipped or duplicated, index 5 follows.
REQ-035 start_i pulsed at beat 7 -> ignored; exactly one done_o pulse; total 32 beats.
REQ-036 abort_i at index 10 in SEND -> next cycle dump_valid_o=0 and busy_o=0, no done_o; a following start_i dumps from index 0.
REQ-037 reset=0 mid-SEND at index 20 -> all outputs 0 immediately, without waiting for clk; after release, a fresh dump completes normally.
REQ-038 FIRST_REG=29, LAST_REG=31 -> exactly 3 beats with indices 29, 30, 31, then a done_o pulse.

Source files
------------

// File: rtl/reg_file_dump_reader.sv
// Register-file dump reader.
// Walks register indices FIRST_REG..LAST_REG through a combinational read
// port and presents each captured value as a valid/ready output beat.
// One beat every two cycles when the consumer is always ready. A dump can be
// abandoned with abort_i. An abandoned dump gives no done_o pulse.
// The block never writes the register file.
module reg_file_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [4:0]  read_register_o,
  input  logic [31:0] read_data_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o,
  output logic [4:0]  dump_index_o,
  output logic        busy_o,
  output logic        done_o
);

  // State encodings are kept as plain constants for compatibility with
  // older tools that consume this block.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  logic [1:0]  state;
  logic [4:0]  index;
  logic        valid_q;
  logic [31:0] data_q;
  logic [4:0]  index_q;

  // The read port always follows the walking index. The read data is
  // combinational, so one READ cycle is enough to capture it.
  assign read_register_o = index;
  assign dump_valid_o    = valid_q;
  assign dump_data_o     = data_q;
  assign dump_index_o    = index_q;

  // Status flags come straight from the state. A reset or an abort clears
  // them as soon as the state returns to IDLE.
  assign busy_o = (state == READ) || (state == SEND);
  assign done_o = (state == DONE);

  // Dump sequencer: capture in READ, hold the beat in SEND until it is
  // accepted, then advance the index or finish. Abort overrides a handshake
  // in the same cycle. A beat accepted in that cycle still counts as
  // delivered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      index   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            index <= FIRST_IDX;
            state <= READ;
          end
        end
        READ: begin
          if (abort_i) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end else begin
            data_q  <= read_data_i;
            index_q <= index;
            valid_q <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (abort_i) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end else if (dump_ready_i) begin
            valid_q <= 1'b0;
            if (index == LAST_IDX) begin
              state <= DONE;
            end else begin
              index <= index + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
